// File: rtl/crc8_serial_unit_if.sv
// Bit-stream and result bundle for crc8_serial_unit.
// The master side is the upstream serialiser and frame-check logic; the slave side is the CRC unit.
interface crc8_serial_unit_if;
  logic       start;
  logic       bit_in;
  logic       bit_valid;
  logic [7:0] crc_exp;
  logic       busy;
  logic [7:0] crc_out;
  logic       crc_valid;
  logic       crc_err;

  modport master (
    output start, bit_in, bit_valid, crc_exp,
    input  busy, crc_out, crc_valid, crc_err
  );

  modport slave (
    input  start, bit_in, bit_valid, crc_exp,
    output busy, crc_out, crc_valid, crc_err
  );
endinterface

// File: rtl/crc8_serial_unit.sv
// Serial MSB-first CRC-8 generator/checker using an XOR-feedback shift register.
// Reports the frame CRC and a mismatch flag against the expected CRC captured with the last bit.
module crc8_serial_unit #(
  parameter logic [7:0] POLY       = 8'h07,
  parameter logic [7:0] INIT       = 8'h00,
  parameter int         FRAME_BITS = 16
) (
  input logic clk,
  input logic rst_n,
  crc8_serial_unit_if.slave bus
);
  localparam int CW = $clog2(FRAME_BITS + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]    state_reg, state_next;
  logic [7:0]    crc_reg, crc_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [7:0]    exp_reg, exp_next;
  logic [7:0]    crc_out_reg, crc_out_next;
  logic          err_reg, err_next;

  logic       fb;
  logic [7:0] crc_step;
  logic       last_bit;
  logic       in_done;
  logic       done_err;

  assign fb = crc_reg[7] ^ bus.bit_in;

  // One XOR tap per register bit, enabled where POLY has a 1.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_tap
      if (gi == 0) begin : g_lsb
        assign crc_step[gi] = fb & POLY[gi];
      end else begin : g_upper
        assign crc_step[gi] = crc_reg[gi-1] ^ (fb & POLY[gi]);
      end
    end
  endgenerate

  assign last_bit = (cnt_reg == CW'(FRAME_BITS - 1));
  assign in_done  = (state_reg == DONE);
  assign done_err = (crc_reg != exp_reg);

  always_comb begin
    state_next   = state_reg;
    crc_next     = crc_reg;
    cnt_next     = cnt_reg;
    exp_next     = exp_reg;
    crc_out_next = crc_out_reg;
    err_next     = err_reg;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          state_next = SHIFT;
          crc_next   = INIT;
          cnt_next   = '0;
        end
      end
      SHIFT: begin
        // start outranks a coincident bit: the frame restarts and that bit is dropped
        if (bus.start) begin
          crc_next = INIT;
          cnt_next = '0;
        end else if (bus.bit_valid) begin
          crc_next = crc_step;
          cnt_next = cnt_reg + CW'(1);
          if (last_bit) begin
            exp_next   = bus.crc_exp;
            state_next = DONE;
          end
        end
      end
      DONE: begin
        crc_out_next = crc_reg;
        err_next     = done_err;
        state_next   = IDLE;
        if (bus.start) begin
          state_next = SHIFT;
          crc_next   = INIT;
          cnt_next   = '0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      crc_reg     <= INIT;
      cnt_reg     <= '0;
      exp_reg     <= 8'h00;
      crc_out_reg <= 8'h00;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      crc_reg     <= crc_next;
      cnt_reg     <= cnt_next;
      exp_reg     <= exp_next;
      crc_out_reg <= crc_out_next;
      err_reg     <= err_next;
    end
  end

  // The DONE cycle presents the fresh result alongside crc_valid; the held copy covers every other cycle.
  assign bus.crc_out   = in_done ? crc_reg  : crc_out_reg;
  assign bus.crc_err   = in_done ? done_err : err_reg;
  assign bus.crc_valid = in_done;
  assign bus.busy      = (state_reg == SHIFT);
endmodule
